instr_loader: RTL
=================

# instr_loader

Encodes RV32I instructions from an upstream field-level host interface into 32-bit words and writes them sequentially into the multicycle core's unified instruction/data memory. It performs the inverse of the core's decode stage: opcode, funct3, funct7 bit, register indices and immediate in, packed word out. It holds the core in reset until the program is loaded, then releases it.

## Interface
- DEPTH, 64, maximum words written; MemAdr spans 0 to 4*(DEPTH-1)
- clk  in  1  sole clock; all logic on the rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- InValid  in  1  host presents a valid instruction record
- InReady  out  1  loader accepts the record this cycle
- InLast  in  1  record is the final instruction of the program
- Op  in  7  opcode
- Funct3  in  3  funct3
- Funct7  in  1  instruction bit 30; used by R-type only
- Rd, Rs1, Rs2  in  5 each  register indices
- Imm  in  32  signed immediate, byte offset for B/J
- MemWrite  out  1  one-cycle memory write strobe
- MemAdr  out  32  word-aligned byte address
- WriteData  out  32  encoded instruction
- Count  out  $clog2(DEPTH)+1  words written
- Done  out  1  load complete; sticky until reset
- Error  out  1  sticky: at least one record dropped
- CpuResetN  out  1  active-low core reset; low until Done

## Operation
- FSM states: IDLE, ENCODE, WRITE, DONE.
- IDLE: InReady=1. When InValid=1, capture all fields and InLast, then go to ENCODE.
- ENCODE: select the format by Op and register WriteData. A record with an illegal Op or a failed check sets Error. It then returns to IDLE, or goes to DONE if its InLast was set. Memory is not written and Count does not advance.
- Format by Op:
  - 0110011 R: word = {1'b0, Funct7, 5'b0, Rs2, Rs1, Funct3, Rd, Op}.
  - 0010011 and 0000011 I: imm[11:0], Rs1, Funct3, Rd, Op.
  - 0100011 S: imm[11:5], Rs2, Rs1, Funct3, imm[4:0], Op.
  - 1100011 B: imm[12], imm[10:5], Rs2, Rs1, Funct3, imm[4:1], imm[11], Op.
  - 1101111 J: imm[20], imm[10:1], imm[11], imm[19:12], Rd, Op.
  - Any other Op is illegal.
- Unused fields for a format are ignored. For example, Funct7 is ignored for I-type and Rd for S/B.
- WRITE:
  - MemWrite=1, MemAdr = Count*4, WriteData = the encoded word.
  - Count increments at the end of the cycle.
  - Next state is DONE if the captured InLast=1 or Count+1 == DEPTH; otherwise IDLE.
- DONE: Done=1, CpuResetN=1, InReady=0. It is left only by reset. Any further records are never accepted.
- Full: after the DEPTH-th write the loader enters DONE regardless of InLast. Error is not set by a full condition.

## Timing
- Reset values: state IDLE, InReady=1 only after reset deasserts, MemWrite=0, MemAdr=0, WriteData=0, Count=0, Done=0, Error=0, CpuResetN=0.
- While reset=0: InReady=0 and no capture occurs.
- Record accepted at edge N (InValid & InReady). MemWrite is high during cycle N+2. InReady is high again in cycle N+3.
- Throughput: one word per 3 cycles.
- Dropped record: no MemWrite. InReady returns in cycle N+2.
- CpuResetN and Done rise in the cycle after the final WRITE or dropped-last ENCODE, and stay high.
- MemWrite is a single-cycle pulse. MemAdr and WriteData are valid whenever MemWrite=1 and hold their values otherwise.
- Reset asserted in any state, including mid-WRITE: next edge returns to the reset values. A write in progress at that edge completes only if MemWrite was already sampled by memory.
- InValid may be asserted without waiting for InReady. Fields must stay stable until acceptance.

## Configuration
- LOADER_RANGE_CHECK_EN defined:
  - ENCODE also checks the immediate range.
  - I/S: Imm must lie in [-2048, 2047].
  - B: Imm must lie in [-4096, 4094] and be even.
  - J: Imm must lie in [-1048576, 1048574] and be even.
  - Failing records are dropped and set Error.
- Undefined: no range check. Imm is truncated to the format's bits, and the low bit of B/J is discarded. Error is raised only by illegal opcodes.

## Test plan
- addi x1,x0,5 then add x3,x1,x2 then sub x3,x1,x2 (Funct7=1, InLast) -> writes 0x00500093@0, 0x002081B3@4, 0x402081B3@8; Count=3, Done=1, CpuResetN=1, MemWrite exactly 2 cycles after each accept.
- sw x2,8(x1); beq x1,x2,-4; jal x1,8 (InLast) -> 0x0020A423@0, 0xFE208EE3@4, 0x008000EF@8.
- Op=0110111 record, then addi x1,x0,5 (InLast) -> no write for the first record, Error=1, 0x00500093@0, Count=1.
- addi x1,x0,2048 (InLast):
  - With LOADER_RANGE_CHECK_EN -> no write, Error=1, Done=1.
  - Without the macro -> 0x80000093@0, Error=0.
- DEPTH=4, 5 records with InValid held high and no InLast -> 4 writes at addresses 0..12, Done=1, InReady=0, fifth record never accepted.
- Reset low during WRITE of the second word -> next cycle Count=0, MemWrite=0, Error=0, CpuResetN=0, InReady=0. After release, the first accepted record writes to address 0.

Source files
------------

// File: rtl/instr_loader.sv
// RV32I field-to-word encoder that loads a program into core memory.
// Optional LOADER_RANGE_CHECK_EN drops records whose immediate will not fit.
module instr_loader #(
  parameter int DEPTH = 64,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic          InLast,
  input  logic [6:0]    Op,
  input  logic [2:0]    Funct3,
  input  logic          Funct7,
  input  logic [4:0]    Rd,
  input  logic [4:0]    Rs1,
  input  logic [4:0]    Rs2,
  input  logic [31:0]   Imm,
  output logic          MemWrite,
  output logic [31:0]   MemAdr,
  output logic [31:0]   WriteData,
  output logic [CW-1:0] Count,
  output logic          Done,
  output logic          Error,
  output logic          CpuResetN
);

  typedef enum logic [1:0] {
    IDLE, ENCODE, WRITE, DONE
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  state_t      state;
  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic        f7_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [31:0] imm_q;
  logic        last_q;

  logic [31:0] word;
  logic        legal;
  logic        fit;
  logic        full;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op_q)
      OP_R: word = {1'b0, f7_q, 5'b0, rs2_q, rs1_q,
                    f3_q, rd_q, op_q};
      OP_I, OP_L:
        word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
      OP_S: word = {imm_q[11:5], rs2_q, rs1_q, f3_q,
                    imm_q[4:0], op_q};
      OP_B: word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q,
                    f3_q, imm_q[4:1], imm_q[11], op_q};
      OP_J: word = {imm_q[20], imm_q[10:1], imm_q[11],
                    imm_q[19:12], rd_q, op_q};
      default: legal = 1'b0;
    endcase
  end

`ifdef LOADER_RANGE_CHECK_EN
  logic signed [31:0] simm;
  assign simm = $signed(imm_q);

  always_comb begin
    fit = 1'b1;
    case (op_q)
      OP_I, OP_L, OP_S:
        fit = (simm >= -32'sd2048) && (simm <= 32'sd2047);
      OP_B:
        fit = (simm >= -32'sd4096) && (simm <= 32'sd4094)
              && !imm_q[0];
      OP_J:
        fit = (simm >= -32'sd1048576)
              && (simm <= 32'sd1048574) && !imm_q[0];
      default: fit = 1'b1;
    endcase
  end
`else
  // Upper immediate bits are simply truncated in this build.
  logic unused_imm;
  assign unused_imm = ^imm_q[31:21];
  assign fit = 1'b1;
`endif

  assign full = (Count + 1'b1) == CW'(DEPTH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      InReady   <= 1'b0;
      MemWrite  <= 1'b0;
      MemAdr    <= '0;
      WriteData <= '0;
      Count     <= '0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      CpuResetN <= 1'b0;
      op_q      <= '0;
      f3_q      <= '0;
      f7_q      <= 1'b0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      MemWrite <= 1'b0;
      case (state)
        IDLE: begin
          InReady <= 1'b1;
          if (InValid && InReady) begin
            op_q    <= Op;
            f3_q    <= Funct3;
            f7_q    <= Funct7;
            rd_q    <= Rd;
            rs1_q   <= Rs1;
            rs2_q   <= Rs2;
            imm_q   <= Imm;
            last_q  <= InLast;
            InReady <= 1'b0;
            state   <= ENCODE;
          end
        end
        ENCODE: begin
          if (legal && fit) begin
            WriteData <= word;
            MemAdr    <= {{(30-CW){1'b0}}, Count, 2'b00};
            MemWrite  <= 1'b1;
            state     <= WRITE;
          end else begin
            Error <= 1'b1;
            if (last_q) begin
              Done      <= 1'b1;
              CpuResetN <= 1'b1;
              state     <= DONE;
            end else begin
              InReady <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        WRITE: begin
          Count <= Count + 1'b1;
          if (last_q || full) begin
            Done      <= 1'b1;
            CpuResetN <= 1'b1;
            state     <= DONE;
          end else begin
            InReady <= 1'b1;
            state   <= IDLE;
          end
        end
        DONE: InReady <= 1'b0;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
